// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types for the calculator datapath: the operation encoding driven by
// the op switches and the result-sequencing FSM state encoding.
// -----------------------------------------------------------------------------
package calc_pkg;

  // Operation select as wired on the op switches.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  // IDLE: waiting for a result request; CALC: iterative mul/div running;
  // DONE: result register holds a finished value.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } calc_state_t;

endpackage

// File: rtl/calc_datapath_if.sv
// -----------------------------------------------------------------------------
// calc_datapath_if
// Bundle between the state selector / display driver side (master) and the
// calculator datapath (slave).
//   en1, en2, en3 : one-hot entry-state enables (A entry, B entry, result)
//   sw            : operand switches, unsigned, WIDTH bits
//   op            : operation select
//   display       : 2*WIDTH value for the display driver
//   busy          : iterative computation in progress
//   result_valid  : result register holds a finished result
//   neg           : subtract result was negative (display shows magnitude)
//   err_div0      : divide attempted with B = 0
// -----------------------------------------------------------------------------
interface calc_datapath_if #(
  parameter int WIDTH = 8
);
  import calc_pkg::*;

  logic                 en1;
  logic                 en2;
  logic                 en3;
  logic [WIDTH-1:0]     sw;
  op_t                  op;
  logic [2*WIDTH-1:0]   display;
  logic                 busy;
  logic                 result_valid;
  logic                 neg;
  logic                 err_div0;

  modport master (
    output en1, en2, en3, sw, op,
    input  display, busy, result_valid, neg, err_div0
  );

  modport slave (
    input  en1, en2, en3, sw, op,
    output display, busy, result_valid, neg, err_div0
  );

endinterface

// File: rtl/seq_muldiv.sv
// -----------------------------------------------------------------------------
// seq_muldiv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per
// step. The parent owns the iteration count and sequencing.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture operands and mode (is_div) for a new operation
//   is_div     : 1 = a / b, 0 = a * b
//   a, b       : operands
//   step       : advance one iteration
//   out        : value the work register takes after the current step
//                (product, or {remainder, quotient}); valid as a final
//                result on the cycle the last step is applied
// -----------------------------------------------------------------------------
module seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 step,
  output logic [2*WIDTH-1:0]   out
);

  // Work register layout, shared by both modes:
  //   mul: [2W] unused (0), [2W-1:W] partial product high, [W-1:0] multiplier
  //        bits still to consume / product low bits shifted in
  //   div: [2W:W] partial remainder (W+1 bits), [W-1:0] dividend bits still to
  //        consume / quotient bits shifted in
  logic [2*WIDTH:0]   work;
  logic [2*WIDTH:0]   work_next;
  logic [WIDTH-1:0]   operand;   // multiplicand (mul) or divisor (div)
  logic               div_mode;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH+1:0]   diff;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    work_next = work;
    addend    = '0;
    sum       = '0;
    shifted   = '0;
    diff      = '0;
    if (div_mode) begin
      // Shift next dividend bit into the remainder, then trial-subtract.
      // A clear borrow bit means the subtraction stands and the quotient
      // bit is 1; otherwise the shifted remainder is kept (restored).
      shifted   = {work[2*WIDTH-1:0], 1'b0};
      diff      = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, operand};
      work_next = shifted;
      if (!diff[WIDTH+1]) begin
        work_next[2*WIDTH:WIDTH] = diff[WIDTH:0];
        work_next[0]             = 1'b1;
      end
    end else begin
      // Add multiplicand when the current multiplier LSB is set, then shift
      // the whole {high, low} pair right by one.
      addend    = work[0] ? operand : '0;
      sum       = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      work_next = {1'b0, sum, work[WIDTH-1:1]};
    end
  end

  // Bit 2W is always 0 once a step completes (remainder < divisor), so the
  // low 2W bits are the product or {remainder, quotient} directly.
  assign out = work_next[2*WIDTH-1:0];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work     <= '0;
      operand  <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      div_mode <= is_div;
      operand  <= is_div ? b : a;
      work     <= {{(WIDTH+1){1'b0}}, (is_div ? a : b)};
    end else if (step) begin
      work     <= work_next;
    end
  end

endmodule

// File: rtl/calc_datapath.sv
// -----------------------------------------------------------------------------
// calc_datapath
// Calculator datapath downstream of the button-driven state selector.
// Captures operand A while en1 is high and operand B while en2 is high; on
// the rising edge of en3 computes A op B (add/sub in one cycle, mul/div over
// WIDTH cycles in seq_muldiv) and presents the value on the display bus.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : calc_datapath_if.slave (enables, switches, op, display, status)
// -----------------------------------------------------------------------------
module calc_datapath
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  calc_datapath_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 en3_d;
  calc_state_t          state;
  calc_state_t          state_next;
  logic [CNT_W-1:0]     counter;
  logic [2*WIDTH-1:0]   result;
  logic                 neg_q;
  logic                 err_q;

  logic                 start;
  logic                 unit_load;
  logic                 unit_step;
  logic                 last_step;
  logic [2*WIDTH-1:0]   unit_out;
  logic [WIDTH:0]       sum_ab;
  logic [WIDTH-1:0]     diff_ab;
  logic                 b_gt_a;

  // Start edge: first cycle of en3 after it has been low for an edge.
  assign start = bus.en3 && !en3_d;

  assign sum_ab  = {1'b0, a_q} + {1'b0, b_q};
  assign b_gt_a  = b_q > a_q;
  assign diff_ab = b_gt_a ? (b_q - a_q) : (a_q - b_q);

  seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load   (unit_load),
    .is_div (bus.op == OP_DIV),
    .a      (a_q),
    .b      (b_q),
    .step   (unit_step),
    .out    (unit_out)
  );

  // Next-state and iteration-unit control.
  always_comb begin
    state_next = state;
    unit_load  = 1'b0;
    unit_step  = 1'b0;
    last_step  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (bus.op)
            OP_MUL: begin
              unit_load  = 1'b1;
              state_next = CALC;
            end
            OP_DIV: begin
              if (b_q != '0) begin
                unit_load  = 1'b1;
                state_next = CALC;
              end else begin
                state_next = DONE;
              end
            end
            default: state_next = DONE;
          endcase
        end
      end
      CALC: begin
        // Dropping en3 mid-calculation abandons the partial work.
        if (!bus.en3) begin
          state_next = IDLE;
        end else begin
          unit_step = 1'b1;
          if (counter == CNT_W'(1)) begin
            last_step  = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (!bus.en3) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Operand capture runs regardless of FSM state; en1 wins over en2.
  // NOTE: every register here, operands and result included, is cleared by
  // reset so the display and status come up at a defined zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      en3_d <= 1'b0;
    end else begin
      en3_d <= bus.en3;
      if (bus.en1)      a_q <= bus.sw;
      else if (bus.en2) b_q <= bus.sw;
    end
  end

  // Result register, flags and iteration counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result  <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      counter <= '0;
    end else if (state == IDLE && start) begin
      neg_q <= 1'b0;
      err_q <= 1'b0;
      unique case (bus.op)
        OP_ADD: result <= {{(WIDTH-1){1'b0}}, sum_ab};
        OP_SUB: begin
          result <= {{WIDTH{1'b0}}, diff_ab};
          neg_q  <= b_gt_a;
        end
        OP_MUL: counter <= CNT_W'(WIDTH);
        OP_DIV: begin
          if (b_q == '0) begin
            result <= '0;
            err_q  <= 1'b1;
          end else begin
            counter <= CNT_W'(WIDTH);
          end
        end
        default: ;
      endcase
    end else if (unit_step) begin
      counter <= counter - CNT_W'(1);
      if (last_step) result <= unit_out;
    end
  end

  assign bus.busy         = (state == CALC);
  assign bus.result_valid = (state == DONE);
  assign bus.neg          = neg_q;
  assign bus.err_div0     = err_q;

  // Live switches while entering an operand, finished result in the result
  // state, blank otherwise.
  always_comb begin
    bus.display = '0;
    if (bus.en1 || bus.en2)                 bus.display = {{WIDTH{1'b0}}, bus.sw};
    else if (bus.en3 && bus.result_valid)   bus.display = result;
  end

endmodule

// File: tb/tb_calc_datapath.sv
// -----------------------------------------------------------------------------
// tb_calc_datapath
// Scoreboard bench for calc_datapath (WIDTH = 8). Stimulus pushes the
// hand-computed expected result of each operation; a monitor pops and
// compares whenever result_valid rises.
// -----------------------------------------------------------------------------
module tb_calc_datapath;
  import calc_pkg::*;

  localparam int WIDTH = 8;

  typedef struct {
    string       name;
    logic [15:0] display;
    logic        neg;
    logic        err;
    int          busy_cycles;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc_datapath_if #(.WIDTH(WIDTH)) bus ();

  calc_datapath #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    int   busy_run;
    logic rv_prev;
    exp_t e;
    busy_run = 0;
    rv_prev  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset || !bus.en3) busy_run = 0;
      else if (bus.busy)     busy_run++;
      if (bus.result_valid && !rv_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_result_sb_size", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check({e.name, "_display"}, bus.display, e.display);
          check({e.name, "_neg"}, bus.neg, e.neg);
          check({e.name, "_err_div0"}, bus.err_div0, e.err);
          check({e.name, "_latency_cycle"}, cyc, e.due);
          check({e.name, "_busy_cycles"}, busy_run, e.busy_cycles);
        end
      end
      rv_prev = bus.result_valid;
    end
  end

  task automatic capture(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.en1 = 1'b1;
    bus.sw  = a;
    @(negedge clk);
    check("display_during_en1", bus.display, {8'h00, a});
    bus.en1 = 1'b0;
    bus.en2 = 1'b1;
    bus.sw  = b;
    @(negedge clk);
    bus.en2 = 1'b0;
    bus.sw  = '0;
  endtask

  // Raise en3 with op, expect a result lat cycles after the start edge.
  task automatic run_op(input string name, input op_t op, input logic [15:0] disp,
                        input logic neg, input logic err, input int lat);
    exp_t e;
    @(negedge clk);
    bus.op  = op;
    bus.en3 = 1'b1;
    e.name = name;
    e.display = disp;
    e.neg = neg;
    e.err = err;
    e.busy_cycles = lat;
    e.due = cyc + 1 + lat;
    sb.push_back(e);
    for (int i = 0; i < lat + 4 && !bus.result_valid; i++) @(negedge clk);
    check({name, "_completed"}, bus.result_valid, 1);
    @(negedge clk);
    check({name, "_display_hold"}, bus.display, disp);
    bus.en3 = 1'b0;
    @(negedge clk);
    check({name, "_valid_clear"}, bus.result_valid, 0);
    check({name, "_display_blank"}, bus.display, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    bus.en1 = 1'b0;
    bus.en2 = 1'b0;
    bus.en3 = 1'b0;
    bus.sw  = '0;
    bus.op  = OP_ADD;
    #12;
    check("reset_display", bus.display, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_result_valid", bus.result_valid, 0);
    check("reset_neg", bus.neg, 0);
    check("reset_err_div0", bus.err_div0, 0);
    @(negedge clk);
    reset = 1'b0;

    capture(8'd200, 8'd100);
    run_op("add_200_100", OP_ADD, 16'h012C, 1'b0, 1'b0, 0);
    capture(8'd255, 8'd255);
    run_op("add_255_255", OP_ADD, 16'h01FE, 1'b0, 1'b0, 0);
    capture(8'd5, 8'd9);
    run_op("sub_5_9", OP_SUB, 16'h0004, 1'b1, 1'b0, 0);
    capture(8'd9, 8'd5);
    run_op("sub_9_5", OP_SUB, 16'h0004, 1'b0, 1'b0, 0);
    capture(8'd255, 8'd255);
    run_op("mul_255_255", OP_MUL, 16'hFE01, 1'b0, 1'b0, 8);
    capture(8'd200, 8'd7);
    run_op("div_200_7", OP_DIV, 16'h041C, 1'b0, 1'b0, 8);
    capture(8'd200, 8'd0);
    run_op("div_200_0", OP_DIV, 16'h0000, 1'b0, 1'b1, 0);
    capture(8'd3, 8'd3);
    run_op("sub_3_3", OP_SUB, 16'h0000, 1'b0, 1'b0, 0);

    // Abort: en3 dropped so that it is sampled low at E+3.
    capture(8'd13, 8'd11);
    @(negedge clk);
    bus.op  = OP_MUL;
    bus.en3 = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_busy_before_drop", bus.busy, 1);
    bus.en3 = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_result_valid", bus.result_valid, 0);
    run_op("mul_13_11_restart", OP_MUL, 16'h008F, 1'b0, 1'b0, 8);

    // Asynchronous reset between edges, after edge E+4 of a multiply.
    capture(8'd255, 8'd255);
    @(negedge clk);
    bus.op  = OP_MUL;
    bus.en3 = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #3;
    check("pre_reset_busy", bus.busy, 1);
    reset   = 1'b1;
    bus.en3 = 1'b0;
    #1;
    check("async_reset_busy", bus.busy, 0);
    check("async_reset_result_valid", bus.result_valid, 0);
    check("async_reset_display", bus.display, 0);
    check("async_reset_neg", bus.neg, 0);
    check("async_reset_err_div0", bus.err_div0, 0);
    @(negedge clk);
    reset = 1'b0;
    // Operands were cleared by reset: A + B must be 0.
    run_op("add_cleared_operands", OP_ADD, 16'h0000, 1'b0, 1'b0, 0);
    capture(8'd100, 8'd10);
    run_op("div_100_10", OP_DIV, 16'h000A, 1'b0, 1'b0, 8);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
